// File: rtl/paralelo_serial_phytx_if.sv
// ----------------------------------------------------------------------------
// paralelo_serial_phytx_if
// Bundles the byte-side handshake and the serial-side outputs of the PHY
// transmit serializer so that producer and serializer share one connection.
//
// Signals:
//   in_data    [7:0] byte offered by the producer
//   in_valid         in_data is valid
//   in_ready         serializer FIFO can take a byte (not full)
//   serial           registered serial line, MSB first
//   byte_start       pulse coincident with bit 7 of every transmitted byte
//   tx_is_data       high for the 8 bit-cycles of a FIFO data byte
//   sync_done        high once the post-reset comma burst is finished
//
// Modports:
//   master : producer / line observer side
//   slave  : serializer side
// ----------------------------------------------------------------------------
interface paralelo_serial_phytx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       serial;
    logic       byte_start;
    logic       tx_is_data;
    logic       sync_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  serial,
        input  byte_start,
        input  tx_is_data,
        input  sync_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output serial,
        output byte_start,
        output tx_is_data,
        output sync_done
    );
endinterface

// File: rtl/paralelo_serial_phytx.sv
// ----------------------------------------------------------------------------
// paralelo_serial_phytx
// Transmit-side PHY serializer. Bytes are accepted over a valid/ready
// handshake into a small FIFO and shifted out MSB first, one bit per clk,
// back to back. When no data byte is available the comma symbol is sent.
// After reset a burst of SYNC_COMMAS commas is sent before any data so the
// receiver can lock its byte alignment.
//
// Optional build macro: PHYTX_PERIODIC_COMMA_EN
//   When defined, a comma is forced after every COMMA_PERIOD consecutive
//   data bytes even if the FIFO still holds data.
//
// Ports:
//   clk    : bit clock, one serial bit per rising edge
//   reset  : synchronous, active-high; aborts the current byte, empties FIFO
//   phy    : paralelo_serial_phytx_if.slave (handshake + serial outputs)
// ----------------------------------------------------------------------------
module paralelo_serial_phytx #(
    parameter int         DEPTH        = 4,
    parameter int         SYNC_COMMAS  = 4,
    parameter logic [7:0] COMMA        = 8'hBC,
    parameter int         COMMA_PERIOD = 16
) (
    input logic                    clk,
    input logic                    reset,
    paralelo_serial_phytx_if.slave phy
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(SYNC_COMMAS + 1);

    localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   ONE_CNT   = (PW + 1)'(1);
    localparam logic [PW-1:0] ONE_PTR   = PW'(1);
    localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_COMMAS - 1);
    localparam logic [SW-1:0] ONE_SYNC  = SW'(1);
`ifdef PHYTX_PERIODIC_COMMA_EN
    localparam int            CW         = $clog2(COMMA_PERIOD + 1);
    localparam logic [CW-1:0] PERIOD_END = CW'(COMMA_PERIOD);
    localparam logic [CW-1:0] ONE_PER    = CW'(1);
`endif

    // Reject configurations the FIFO pointer arithmetic cannot support.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_COMMAS < 1 || COMMA_PERIOD < 1) begin : g_badParam
            $error("paralelo_serial_phytx: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {
        SYNC,
        RUN
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0]   r_count;
    logic [7:0]    r_cur;
    logic          r_curIsData;
    logic [2:0]    r_bitCnt;
    logic [SW-1:0] r_syncCnt;
    logic          r_serial;
    logic          r_byteStart;
    logic          r_txIsData;
    logic          r_syncDone;
`ifdef PHYTX_PERIODIC_COMMA_EN
    logic [CW-1:0] r_periodCnt;
`endif

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_boundary;
    logic w_runSel;
    logic w_forceComma;

    // Byte selection at a boundary. The boundary that ends the last sync
    // comma already follows the RUN rules, so exactly SYNC_COMMAS commas
    // precede the first data byte.
    always_comb begin
        w_full     = (r_count == DEPTH_CNT);
        w_empty    = (r_count == '0);
        w_push     = phy.in_valid && !w_full;
        w_boundary = (r_bitCnt == 3'd0);
        w_runSel   = (r_state == RUN) || (r_syncCnt == LAST_SYNC);
`ifdef PHYTX_PERIODIC_COMMA_EN
        w_forceComma = (r_periodCnt == PERIOD_END);
`else
        w_forceComma = 1'b0;
`endif
        w_pop = w_boundary && w_runSel && !w_empty && !w_forceComma;
    end

    // FIFO storage has no reset; stale entries are unreachable once the
    // pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= phy.in_data;
        end
    end

    // Serializer, FIFO bookkeeping and SYNC/RUN sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SYNC;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_cur       <= COMMA;
            r_curIsData <= 1'b0;
            r_bitCnt    <= 3'd7;
            r_syncCnt   <= '0;
            r_serial    <= 1'b0;
            r_byteStart <= 1'b0;
            r_txIsData  <= 1'b0;
            r_syncDone  <= 1'b0;
`ifdef PHYTX_PERIODIC_COMMA_EN
            r_periodCnt <= '0;
`endif
        end else begin
            r_serial    <= r_cur[r_bitCnt];
            r_byteStart <= (r_bitCnt == 3'd7);
            r_txIsData  <= r_curIsData;

            if (w_push) begin
                r_wrPtr <= r_wrPtr + ONE_PTR;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ONE_PTR;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - ONE_CNT;
            end

            if (w_boundary) begin
                r_bitCnt <= 3'd7;
                if (w_pop) begin
                    r_cur       <= r_mem[r_rdPtr];
                    r_curIsData <= 1'b1;
                end else begin
                    r_cur       <= COMMA;
                    r_curIsData <= 1'b0;
                end
                if (r_state == SYNC) begin
                    r_syncCnt <= r_syncCnt + ONE_SYNC;
                    if (r_syncCnt == LAST_SYNC) begin
                        r_state    <= RUN;
                        r_syncDone <= 1'b1;
                    end
                end
`ifdef PHYTX_PERIODIC_COMMA_EN
                if (w_runSel) begin
                    if (w_pop) begin
                        r_periodCnt <= r_periodCnt + ONE_PER;
                    end else begin
                        r_periodCnt <= '0;
                    end
                end
`endif
            end else begin
                r_bitCnt <= r_bitCnt - 3'd1;
            end
        end
    end

    assign phy.in_ready   = !w_full;
    assign phy.serial     = r_serial;
    assign phy.byte_start = r_byteStart;
    assign phy.tx_is_data = r_txIsData;
    assign phy.sync_done  = r_syncDone;

endmodule

// File: doc/paralelo_serial_phytx.md
Name: paralelo_serial_phytx

Overview:
Transmit-side PHY serializer. It is the upstream stage that drives the serial line into the receive-side serial-to-parallel converter. Bytes arrive over a valid/ready handshake and are buffered in a small FIFO. Each byte is shifted out MSB-first, one bit per clk, and the comma byte 0xBC is inserted whenever no data is available. After reset a burst of commas is sent so the receiver can lock its byte alignment before any data.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
SYNC_COMMAS, 4, number of commas sent after reset before data is allowed.
COMMA, 8'hBC, idle/alignment symbol.
COMMA_PERIOD, 16, data bytes between forced commas (used only with the optional feature).

Ports:
clk  input  1  bit clock; one serial bit per rising edge.
reset  input  1  synchronous, active-high.
in_data  input  8  byte to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  FIFO can accept a byte (equals not full).
serial  output  1  registered serial line, MSB-first.
byte_start  output  1  one-cycle pulse coincident with bit 7 of every transmitted byte.
tx_is_data  output  1  high for all 8 bit-cycles of a FIFO data byte; low during commas.
sync_done  output  1  high once the SYNC phase has completed.

Behaviour:
- Clocking and reset: clock clk; reset is synchronous, active-high.
- Reset values:
  - serial=0, byte_start=0, tx_is_data=0, sync_done=0.
  - FIFO empty, so in_ready=1 from the first cycle after reset release.
  - bit_cnt=7, state=SYNC, sync_cnt=0, period_cnt=0.
- Reset asserted mid-byte aborts the byte immediately. The FIFO contents are discarded.
- Serialization:
  - A shift register holds the current byte; serial<=cur[bit_cnt].
  - bit_cnt counts 7 down to 0, then wraps to 7.
  - The first cycle after reset release outputs bit 7 of the first comma. Bytes follow back-to-back with no gap cycles.
- Byte boundary: the cycle in which bit 0 is driven. In that cycle the next byte is selected and loaded, so its bit 7 appears on the following cycle together with byte_start=1.
- State SYNC:
  - Every byte is COMMA; tx_is_data=0; the FIFO is not popped.
  - sync_cnt increments at each byte boundary.
  - When the boundary ends comma number SYNC_COMMAS, go to RUN and set sync_done=1 at that boundary.
  - Pushes are accepted during SYNC.
- State RUN, at each boundary:
  - FIFO non-empty: pop the head and load it; tx_is_data=1 for the next 8 cycles.
  - FIFO empty: load COMMA; tx_is_data=0.
- RUN exits only on reset.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only at a RUN boundary.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - When full, in_ready=0. A pop in that cycle does not raise in_ready combinationally; in_ready rises the next cycle.
  - Pointers are log2(DEPTH) bits and wrap. The occupancy counter is log2(DEPTH)+1 bits.
- Data bytes equal to 0xBC are transmitted verbatim. Avoiding them is the upstream's responsibility.
- Latency: a byte pushed into an empty FIFO in RUN starts on serial at the first boundary after the push cycle. Worst case is 8 cycles plus 1.
- Throughput: 1 byte per 8 clk.

Optional Feature:
PHYTX_PERIODIC_COMMA_EN.
- Defined:
  - period_cnt counts consecutive data bytes loaded in RUN.
  - When period_cnt==COMMA_PERIOD at a boundary, load COMMA even if the FIFO is non-empty. Do not pop, and clear period_cnt.
  - A comma loaded because the FIFO is empty also clears period_cnt.
- Not defined: period_cnt and COMMA_PERIOD logic are absent; commas are sent only in SYNC or when the FIFO is empty.

Test Plan:
1. Reset 3 cycles, then release with no input -> serial sequence 1,0,1,1,1,1,0,0 repeated; byte_start every 8th cycle starting at the first cycle after release; sync_done rises at cycle 32; tx_is_data stays 0.
2. Push 0xA5 at cycle 40 (RUN, FIFO empty) -> byte starting at cycle 49 is 1,0,1,0,0,1,0,1 with tx_is_data=1 for those 8 cycles; the following byte is 0xBC.
3. With in_valid held, push 0x01..0x06 during SYNC -> in_ready drops after 4 accepted bytes; after sync_done, bytes 0x01..0x06 go out back-to-back in order with no comma between them.
4. Simultaneous push and pop with FIFO at count 2 -> count stays 2; the order of all bytes is preserved.
5. Assert reset at bit 4 of a data byte with 3 bytes queued -> serial=0 next cycle; after release the 4-comma SYNC repeats; queued bytes are never sent.
6. With PHYTX_PERIODIC_COMMA_EN and COMMA_PERIOD=3, stream 7 bytes continuously -> output D1 D2 D3 BC D4 D5 D6 BC D7; without the macro -> D1..D7 contiguous.
